// File: rtl/pcs_pkg.sv
// Shared PCS constants for the alignment-marker scheduler: lane count, AM marker
// bytes, sync headers, scheduler state enum and block/BIP helper functions.
package pcs_pkg;

    localparam int unsigned NUM_LANES = 4;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Per-lane marker bytes packed as {M2, M1, M0}; index = PCS lane.
    localparam logic [NUM_LANES-1:0][23:0] AM_MARKER = {
        24'h3D_79_A2,
        24'h9B_65_C5,
        24'hE6_C4_F0,
        24'h47_76_90
    };

    typedef enum logic [0:0] {
        StAm,
        StData
    } am_state_e;

    // AM payload, byte 0 in data[7:0]: M0,M1,M2,BIP3,~M0,~M1,~M2,~BIP3.
    function automatic logic [63:0] am_block(input logic [1:0] lane, input logic [7:0] bip3);
        logic [23:0] m;
        m = AM_MARKER[lane];
        return {~bip3, ~m, bip3, m};
    endfunction

    // One block's share of the BIP: bit j is the parity of bits 8m+j; header folds into 3 and 4.
    function automatic logic [7:0] bip_contrib(input logic [1:0] hdr, input logic [63:0] data);
        logic [7:0] b;
        b = '0;
        for (int m = 0; m < 8; m++) begin
            b = b ^ data[8*m +: 8];
        end
        b[3] = b[3] ^ hdr[0];
        b[4] = b[4] ^ hdr[1];
        return b;
    endfunction

endpackage

// File: rtl/am_bip_acc.sv
// Per-lane BIP accumulator over emitted 66-bit blocks. An AM block reloads the
// accumulator with its own contribution; every other block on the lane XORs in.
module am_bip_acc
    import pcs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        blk_en_i,
    input  logic        load_i,
    input  logic [1:0]  header_i,
    input  logic [63:0] data_i,
    output logic [7:0]  bip_o
);

    logic [7:0] acc_q;
    logic [7:0] contrib;

    assign contrib = bip_contrib(header_i, data_i);
    assign bip_o   = acc_q;

    // Accumulate parity of blocks emitted on this lane; restart on the lane's AM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (blk_en_i) begin
            acc_q <= load_i ? contrib : (acc_q ^ contrib);
        end
    end

endmodule

// File: rtl/am_sched.sv
// Alignment-marker scheduler: emits a four-lane AM group, then 4*AM_INTERVAL
// scrambled data blocks round-robin across the lanes, paced by the gearbox.
// Optional feature: define AM_BIP_EN to carry real per-lane BIP3 in the AMs;
// otherwise BIP3 is 8'h00 and no accumulators exist.
module am_sched
    import pcs_pkg::*;
#(
    parameter int unsigned AM_INTERVAL = 16383
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pace,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_header,
    input  logic [63:0] in_data,
    output logic        scr_en,
    output logic [63:0] scr_data_in,
    input  logic [63:0] scr_data_out,
    output logic        out_valid,
    output logic [1:0]  out_header,
    output logic [63:0] out_data,
    output logic [1:0]  out_lane,
    output logic        out_is_am,
    output logic        underrun
);

    localparam int unsigned BlocksPerGroup = 4 * AM_INTERVAL;
    localparam int unsigned CntW           = $clog2(BlocksPerGroup + 1);
    localparam logic [CntW-1:0] CntLast    = CntW'(BlocksPerGroup - 1);

    am_state_e       state_q, state_d;
    logic [1:0]      lane_q, lane_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        out_valid_q;
    logic [1:0]  out_header_q;
    logic [63:0] out_data_q;
    logic [1:0]  out_lane_q;
    logic        out_is_am_q;

    logic        in_data_st;
    logic        emit_am;
    logic        xfer;
    logic        emit;
    logic [7:0]  bip3;
    logic [1:0]  blk_hdr;
    logic [63:0] blk_data;

    assign in_data_st  = (state_q == StData);
    assign emit_am     = pace && (state_q == StAm);
    assign in_ready    = pace && in_data_st;
    assign xfer        = in_ready && in_valid;
    assign emit        = emit_am || xfer;
    assign underrun    = pace && in_data_st && !in_valid;
    assign scr_en      = xfer;
    assign scr_data_in = in_data;

    // Header bypasses the scrambler; only the payload is scrambled.
    assign blk_hdr  = emit_am ? SYNC_DATA : in_header;
    assign blk_data = emit_am ? am_block(lane_q, bip3) : scr_data_out;

`ifdef AM_BIP_EN
    logic [7:0] bip_lane [NUM_LANES];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_bip
        am_bip_acc u_bip (
            .clk      (clk),
            .reset    (reset),
            .blk_en_i (emit && (lane_q == 2'(l))),
            .load_i   (emit_am),
            .header_i (blk_hdr),
            .data_i   (blk_data),
            .bip_o    (bip_lane[l])
        );
    end

    assign bip3 = bip_lane[lane_q];
`else
    assign bip3 = 8'h00;
`endif

    // Next-state: AM group walks lanes 0..3; data phase counts transfers until the interval ends.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StAm: begin
                if (pace) begin
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        state_d = StData;
                        cnt_d   = '0;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    lane_d = lane_q + 2'd1;
                    if (cnt_q == CntLast) begin
                        state_d = StAm;
                        cnt_d   = '0;
                        lane_d  = 2'd0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = StAm;
                lane_d  = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered output block; outputs hold their last block when nothing is emitted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StAm;
            lane_q       <= 2'd0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_header_q <= 2'b00;
            out_data_q   <= '0;
            out_lane_q   <= 2'd0;
            out_is_am_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            out_valid_q <= emit;
            if (emit) begin
                out_header_q <= blk_hdr;
                out_data_q   <= blk_data;
                out_lane_q   <= lane_q;
                out_is_am_q  <= emit_am;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_header = out_header_q;
    assign out_data   = out_data_q;
    assign out_lane   = out_lane_q;
    assign out_is_am  = out_is_am_q;

endmodule
